// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared states, opcodes and control encodings for the multi-cycle RV32I controller
package multicycle_controller_pkg;
  typedef enum logic [4:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
    MEM_WR, BRANCH, JAL, JAL_PC, JALR, LUI, HALT
  } state_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: shared instruction/data memory port handshake
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic Mem_write;
  logic Adr_src;
  modport master(output mem_req, Mem_write, Adr_src, input mem_ready);
  modport slave(input mem_req, Mem_write, Adr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// multicycle_controller_alu_decoder: func3/func7/op-class to ALU_cntl, shared by R- and I-type execute
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       op_r,
  output logic [2:0] alu_cntl
);
  logic unused_f7;
  assign unused_f7 = ^{func7[6], func7[4:0]};
  always_comb begin
    alu_cntl = func3 == 3'b000 ? ((op_r && func7[5]) ? ALU_SUB : ALU_ADD) :
               func3 == 3'b010 ? ALU_SLT :
               func3 == 3'b100 ? ALU_XOR :
               func3 == 3'b110 ? ALU_OR  :
               func3 == 3'b111 ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing a multi-cycle RV32I datapath; `CTRL_PERF_CNT_EN adds instr_cnt/stall_cnt
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 opc,
  input  logic [2:0]                 func3,
  input  logic [6:0]                 func7,
  input  logic                       zero,
  input  logic                       pos,
  multicycle_controller_if.master    bus,
  output logic                       IR_write,
  output logic                       PC_write,
  output logic                       Reg_write,
  output logic [1:0]                 ALU_src_A,
  output logic [1:0]                 ALU_src_B,
  output logic [2:0]                 ALU_cntl,
  output logic [2:0]                 Imm_src,
  output logic [1:0]                 Result_src,
  output logic                       illegal,
  output logic                       bus_err
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                instr_cnt,
  output logic [31:0]                stall_cnt
`endif
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic [2:0] alu_dec;
  logic taken, br_ok;
  multicycle_controller_alu_decoder u_alu_dec (
    .func3(func3),
    .func7(func7),
    .op_r(state_q == EXEC_R),
    .alu_cntl(alu_dec)
  );
  assign taken = func3 == F3_BEQ ? zero :
                 func3 == F3_BNE ? !zero :
                 func3 == F3_BLT ? (!zero && !pos) :
                 func3 == F3_BGE ? (zero || pos) : 1'b0;
  assign br_ok = func3 == F3_BEQ || func3 == F3_BNE || func3 == F3_BLT || func3 == F3_BGE;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = 32'd0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    bus.mem_req = 1'b0;
    bus.Mem_write = 1'b0;
    bus.Adr_src = 1'b0;
    IR_write = 1'b0;
    PC_write = 1'b0;
    Reg_write = 1'b0;
    ALU_src_A = SRCA_PC;
    ALU_src_B = SRCB_RS2;
    ALU_cntl = ALU_ADD;
    Imm_src = IMM_I;
    Result_src = RES_ALUOUT;
    case (state_q)
      IDLE: begin
        state_d = (cnt_q + 32'd1 >= 32'(RESET_PC_HOLD)) ? FETCH : IDLE;
        cnt_d = (state_d == FETCH) ? 32'd0 : cnt_q + 32'd1;
      end
      FETCH: begin
        bus.mem_req = 1'b1;
        ALU_src_B = SRCB_FOUR;
        Result_src = RES_ALU;
        IR_write = bus.mem_ready;
        PC_write = bus.mem_ready;
        state_d = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALU_src_A = SRCA_OLDPC;
        ALU_src_B = SRCB_IMM;
        Imm_src = IMM_B;
        state_d = opc == OP_R ? EXEC_R :
                  opc == OP_I ? EXEC_I :
                  (opc == OP_LOAD || opc == OP_STORE) ? MEM_ADR :
                  opc == OP_BRANCH ? BRANCH :
                  opc == OP_JAL ? JAL :
                  opc == OP_JALR ? JALR :
                  opc == OP_LUI ? LUI : HALT;
        illegal_d = illegal_q | (state_d == HALT);
      end
      EXEC_R: begin
        ALU_src_A = SRCA_RS1;
        ALU_cntl = alu_dec;
        state_d = ALU_WB;
      end
      EXEC_I: begin
        ALU_src_A = SRCA_RS1;
        ALU_src_B = SRCB_IMM;
        ALU_cntl = alu_dec;
        state_d = ALU_WB;
      end
      ALU_WB: begin
        Reg_write = 1'b1;
        state_d = FETCH;
      end
      MEM_ADR: begin
        ALU_src_A = SRCA_RS1;
        ALU_src_B = SRCB_IMM;
        Imm_src = opc == OP_STORE ? IMM_S : IMM_I;
        state_d = opc == OP_STORE ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.Adr_src = 1'b1;
        state_d = bus.mem_ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        Reg_write = 1'b1;
        Result_src = RES_MEM;
        state_d = FETCH;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.Mem_write = 1'b1;
        bus.Adr_src = 1'b1;
        state_d = bus.mem_ready ? FETCH : MEM_WR;
      end
      BRANCH: begin
        ALU_src_A = SRCA_RS1;
        ALU_cntl = ALU_SUB;
        PC_write = taken;
        illegal_d = illegal_q | !br_ok;
        state_d = FETCH;
      end
      // JAL re-forms the jump target with the J immediate since DECODE used the B format
      JAL: begin
        ALU_src_A = SRCA_OLDPC;
        ALU_src_B = SRCB_IMM;
        Imm_src = IMM_J;
        state_d = JAL_PC;
      end
      JALR: begin
        ALU_src_A = SRCA_RS1;
        ALU_src_B = SRCB_IMM;
        state_d = JAL_PC;
      end
      JAL_PC: begin
        Reg_write = 1'b1;
        PC_write = 1'b1;
        ALU_src_A = SRCA_OLDPC;
        ALU_src_B = SRCB_FOUR;
        Result_src = RES_ALU;
        state_d = FETCH;
      end
      LUI: begin
        Reg_write = 1'b1;
        Result_src = RES_IMM;
        Imm_src = IMM_U;
        state_d = FETCH;
      end
      default: state_d = state_q;
    endcase
    if (bus.mem_req) begin
      cnt_d = bus.mem_ready ? 32'd0 : cnt_q + 32'd1;
      if (MEM_TIMEOUT != 0 && !bus.mem_ready && cnt_q == 32'(MEM_TIMEOUT - 1)) begin
        bus_err_d = 1'b1;
        state_d = HALT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 32'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt_q, instr_cnt_d, stall_cnt_q, stall_cnt_d;
  always_comb begin
    instr_cnt_d = instr_cnt_q + ((state_d == FETCH && state_q != FETCH && state_q != IDLE) ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + ((bus.mem_req && !bus.mem_ready) ? 32'd1 : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign instr_cnt = instr_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of the multi-cycle controller strobes and flags
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opc = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic zero = 1'b0;
  logic pos = 1'b0;
  logic IR_write, PC_write, Reg_write, illegal, bus_err;
  logic [1:0] ALU_src_A, ALU_src_B, Result_src;
  logic [2:0] ALU_cntl, Imm_src;
  logic [17:0] ctl;
  int total = 0;
  int passed = 0;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif
  multicycle_controller_if if_i();
  multicycle_controller #(.MEM_TIMEOUT(16), .RESET_PC_HOLD(1)) dut (
    .clk(clk),
    .rst(rst),
    .opc(opc),
    .func3(func3),
    .func7(func7),
    .zero(zero),
    .pos(pos),
    .bus(if_i.master),
    .IR_write(IR_write),
    .PC_write(PC_write),
    .Reg_write(Reg_write),
    .ALU_src_A(ALU_src_A),
    .ALU_src_B(ALU_src_B),
    .ALU_cntl(ALU_cntl),
    .Imm_src(Imm_src),
    .Result_src(Result_src),
    .illegal(illegal),
    .bus_err(bus_err)
`ifdef CTRL_PERF_CNT_EN
    ,
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign ctl = {if_i.mem_req, if_i.Mem_write, if_i.Adr_src, IR_write, PC_write, Reg_write,
                ALU_src_A, ALU_src_B, ALU_cntl, Imm_src, Result_src};
  // {req,wr,adr, ir,pcw,rw, A, B, alu, imm, res}
  localparam logic [17:0] C_IDLE    = 18'd0;
  localparam logic [17:0] C_FETCH_W = {3'b100, 3'b000, 2'b00, 2'b10, 3'b000, 3'b000, 2'b10};
  localparam logic [17:0] C_FETCH   = {3'b100, 3'b110, 2'b00, 2'b10, 3'b000, 3'b000, 2'b10};
  localparam logic [17:0] C_DEC     = {3'b000, 3'b000, 2'b01, 2'b01, 3'b000, 3'b010, 2'b00};
  localparam logic [17:0] C_ADD     = {3'b000, 3'b000, 2'b10, 2'b00, 3'b000, 3'b000, 2'b00};
  localparam logic [17:0] C_SUB     = {3'b000, 3'b000, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00};
  localparam logic [17:0] C_XORI    = {3'b000, 3'b000, 2'b10, 2'b01, 3'b101, 3'b000, 2'b00};
  localparam logic [17:0] C_AWB     = {3'b000, 3'b001, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
  localparam logic [17:0] C_LDA     = {3'b000, 3'b000, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00};
  localparam logic [17:0] C_STA     = {3'b000, 3'b000, 2'b10, 2'b01, 3'b000, 3'b001, 2'b00};
  localparam logic [17:0] C_MRD     = {3'b101, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
  localparam logic [17:0] C_MWB     = {3'b000, 3'b001, 2'b00, 2'b00, 3'b000, 3'b000, 2'b01};
  localparam logic [17:0] C_MWR     = {3'b111, 3'b000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
  localparam logic [17:0] C_BT      = {3'b000, 3'b010, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00};
  localparam logic [17:0] C_BN      = {3'b000, 3'b000, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00};
  localparam logic [17:0] C_JR      = {3'b000, 3'b000, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00};
  localparam logic [17:0] C_JPC     = {3'b000, 3'b011, 2'b01, 2'b10, 3'b000, 3'b000, 2'b10};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input string tag, input logic rdy, input logic [17:0] exp);
    if_i.mem_ready = rdy;
    #1;
    check(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_dec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opc = o;
    func3 = f3;
    func7 = f7;
    cyc("fetch", 1'b1, C_FETCH);
    cyc("decode", 1'b0, C_DEC);
  endtask
  task automatic do_reset();
    if_i.mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    if_i.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ctl", 32'(ctl), 32'(C_IDLE));
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    cyc("idle", 1'b0, C_IDLE);
    opc = 7'b0110011;
    cyc("fetch_wait", 1'b0, C_FETCH_W);
    cyc("fetch", 1'b1, C_FETCH);
    cyc("decode", 1'b0, C_DEC);
    cyc("exec_add", 1'b0, C_ADD);
    cyc("alu_wb", 1'b0, C_AWB);
    fetch_dec(7'b0110011, 3'b000, 7'b0100000);
    cyc("exec_sub", 1'b0, C_SUB);
    cyc("alu_wb", 1'b0, C_AWB);
    fetch_dec(7'b0010011, 3'b100, 7'b0100000);
    cyc("exec_xori", 1'b0, C_XORI);
    cyc("alu_wb", 1'b0, C_AWB);
    fetch_dec(7'b0000011, 3'b010, 7'd0);
    cyc("ld_adr", 1'b0, C_LDA);
    repeat (3) cyc("ld_wait", 1'b0, C_MRD);
    cyc("ld_done", 1'b1, C_MRD);
    cyc("ld_wb", 1'b0, C_MWB);
    check("ld_bus_err", 32'(bus_err), 32'd0);
    zero = 1'b1;
    pos = 1'b0;
    fetch_dec(7'b1100011, 3'b000, 7'd0);
    cyc("beq_taken", 1'b0, C_BT);
    fetch_dec(7'b1100011, 3'b001, 7'd0);
    cyc("bne_not_taken", 1'b0, C_BN);
    zero = 1'b0;
    fetch_dec(7'b1100011, 3'b100, 7'd0);
    cyc("blt_taken", 1'b0, C_BT);
    fetch_dec(7'b1100011, 3'b101, 7'd0);
    cyc("bge_not_taken", 1'b0, C_BN);
    fetch_dec(7'b1100111, 3'b000, 7'd0);
    cyc("jalr", 1'b0, C_JR);
    cyc("jal_pc", 1'b0, C_JPC);
    check("no_illegal", 32'(illegal), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check("instr_cnt", instr_cnt, 32'd9);
    check("stall_cnt", stall_cnt, 32'd4);
`endif
    fetch_dec(7'b0100011, 3'b010, 7'd0);
    cyc("st_adr", 1'b0, C_STA);
    for (int i = 0; i < 16; i++) cyc("st_wait", 1'b0, C_MWR);
    check("timeout_ctl", 32'(ctl), 32'(C_IDLE));
    check("timeout_bus_err", 32'(bus_err), 32'd1);
    repeat (3) cyc("halt_hold", 1'b1, C_IDLE);
    check("halt_bus_err", 32'(bus_err), 32'd1);
    do_reset();
    check("rst_clears_bus_err", 32'(bus_err), 32'd0);
`ifdef CTRL_PERF_CNT_EN
    check("rst_instr_cnt", instr_cnt, 32'd0);
`endif
    cyc("idle2", 1'b0, C_IDLE);
    fetch_dec(7'b1111111, 3'b000, 7'd0);
    check("illegal_set", 32'(illegal), 32'd1);
    repeat (2) cyc("illegal_halt", 1'b1, C_IDLE);
    check("illegal_sticky", 32'(illegal), 32'd1);
    do_reset();
    check("rst_clears_illegal", 32'(illegal), 32'd0);
    cyc("idle3", 1'b0, C_IDLE);
    cyc("fetch3_wait", 1'b0, C_FETCH_W);
    do_reset();
    check("rst_mid_access", 32'(ctl), 32'(C_IDLE));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised successor to the single-cycle controller: an FSM-based controller for a multi-cycle RV32I datapath that shares one memory port between instructions and data.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Supports variable-latency memory through a req/ready handshake.
- Flags illegal opcodes and detects memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready before flagging a bus error; 0 disables the timeout.
- RESET_PC_HOLD, 1, number of cycles the controller stays in IDLE after reset before the first fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- opc  in  7  instruction opcode, taken from the IR.
- func3  in  3  instruction func3.
- func7  in  7  instruction func7.
- zero  in  1  ALU result == 0.
- pos  in  1  ALU result > 0 (signed).
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- Mem_write  out  1  write strobe; valid only while mem_req=1.
- Adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- IR_write  out  1  load IR and OldPC.
- PC_write  out  1  PC update enable.
- Reg_write  out  1  register file write enable.
- ALU_src_A  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALU_src_B  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ALU_cntl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
- Imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- Result_src  out  2  result mux select: 00 = ALU result register, 01 = memory data register, 10 = ALU output, 11 = imm.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All enables are 0: mem_req, Mem_write, IR_write, PC_write, Reg_write.
  - All selects are 0.
  - illegal=0, bus_err=0, timeout counter=0.
  - Reset asserted mid-access drops mem_req in the next cycle with no write completed.
- IDLE: stay RESET_PC_HOLD cycles, then go to FETCH.
- FETCH:
  - Drive mem_req=1, Adr_src=0.
  - Hold until mem_ready.
  - In the mem_ready cycle: IR_write=1, PC_write=1 with PC+4 (A=00, B=10, add, Result_src=10), then go to DECODE.
- DECODE:
  - Compute OldPC+imm into the ALU result register (A=01, B=01, Imm_src=010).
  - Dispatch on opc: 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEM_ADR; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111 → LUI.
  - Any other opc: set illegal, go to HALT.
- EXEC_R: A=10, B=00, ALU_cntl decoded from func3/func7 (func7[5]=1 with func3=000 → sub). Next state ALU_WB.
- EXEC_I: A=10, B=01, Imm_src=000, ALU_cntl from func3. Next state ALU_WB.
- ALU_WB: Reg_write=1, Result_src=00. Next state FETCH.
- MEM_ADR: A=10, B=01, add; Imm_src=000 for loads, 001 for stores.
  - Next state MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, Adr_src=1; wait for mem_ready, then go to MEM_WB.
- MEM_WB: Reg_write=1, Result_src=01. Next state FETCH.
- MEM_WR: mem_req=1, Mem_write=1, Adr_src=1; wait for mem_ready, then go to FETCH.
- BRANCH: A=10, B=00, sub.
  - Taken condition by func3: 000 beq (zero); 001 bne (!zero); 100 blt (!zero & !pos); 101 bge (zero | pos).
  - If taken: PC_write=1, Result_src=00 (target computed in DECODE).
  - Any other func3 sets illegal.
  - Next state FETCH.
- JAL: Reg_write=1 with OldPC+4 (A=01, B=10, Result_src=10); PC_write=1 from the ALU result register.
  - Two cycles: JAL, then JAL_PC. Next state FETCH.
- JALR: first cycle computes rs1+imm into the ALU result register; second cycle performs the same rd/PC writes as JAL. Next state FETCH.
- LUI: Reg_write=1, Result_src=11, Imm_src=100. Next state FETCH.
- Timeout:
  - A counter increments each cycle mem_req=1 and mem_ready=0, and clears when mem_ready=1.
  - When the counter reaches MEM_TIMEOUT: set bus_err, drop mem_req, go to HALT.
- HALT: all enables 0; leaves only on rst.
- mem_ready while mem_req=0 is ignored.
- Strobes are Moore outputs from state, except the FETCH/MEM strobes, which are gated by mem_ready.

Optional Feature:
- CTRL_PERF_CNT_EN defined:
  - Adds outputs instr_cnt[31:0] and stall_cnt[31:0], both cleared on rst.
  - instr_cnt increments on each transition into FETCH from a completing state.
  - stall_cnt increments on each mem_req && !mem_ready cycle.
  - Both wrap at 2^32.
- Undefined: no counters, no extra ports.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode localparams;
  - ALU_cntl, Imm_src, Result_src and source-select encodings;
  - branch func3 codes.
- Sub-module: alu_decoder (combinational; func3/func7/op-class → ALU_cntl), reused by EXEC_R and EXEC_I.

Test Plan:
- Reset then add x3,x1,x2 (opc 0110011, func3 000, func7 0), mem_ready=1 → states IDLE→FETCH→DECODE→EXEC_R→ALU_WB; Reg_write pulses once; ALU_cntl=000.
- lw with mem_ready delayed 3 cycles in MEM_RD → mem_req held 4 cycles, then MEM_WB with Result_src=01; bus_err=0.
- sw with mem_ready stuck low, MEM_TIMEOUT=16 → bus_err=1 after 16 wait cycles, mem_req drops, controller stays in HALT until rst.
- beq with zero=1 → PC_write=1 in BRANCH; bne with zero=1 → PC_write=0; blt with pos=0, zero=0 → taken.
- opc 1111111 → illegal=1, no Reg_write or Mem_write, HALT; rst clears illegal.
- jalr → two execute cycles, Reg_write=1 and PC_write=1 in the same cycle; with CTRL_PERF_CNT_EN, instr_cnt increments by exactly 1 per instruction.
